rf_mac_engine: RTL
==================

# rf_mac_engine

Sequencer and arithmetic stage that consumes the three registered read ports of the 15×8 signed register file. It writes results back through the register file's single write port. On a start command it runs `len` multiply-accumulate operations, `dst[i] = sat(a[i]*b[i] + c[i])`, and steps all register indices after each one. It is the register file's only master during a run: it owns the file's WriteEn/ReadEn and address lines.

## Interface
- `M`, default 4: register index width.
- `N`, default 15: number of registers. Valid indices are 0..N-1.
- `W`, default 8: data width, signed two's complement.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; clock clk.
- `start`  in  1  command strobe; sampled only in IDLE.
- `len`  in  M  number of operations, 0..N.
- `src_a`, `src_b`, `src_c`, `dst`  in  M each  starting register indices.
- `busy`  out  1  high from the cycle after start is accepted until DONE has finished.
- `done`  out  1  one-cycle pulse at the end of a run. Also pulses for rejected or empty commands.
- `err`  out  1  one-cycle pulse, coincident with `done`, when a command is rejected.
- `sat`  out  1  sticky flag: some result in the current or last run was clipped. Cleared when a start is accepted.
- `rf_read_en`  out  1  drives the file's ReadEn.
- `rf_read_reg1`, `rf_read_reg2`, `rf_read_reg3`  out  M each.
- `rf_write_en`  out  1  drives the file's WriteEn.
- `rf_write_reg`  out  M.
- `rf_write_data`  out  W  signed.
- `rf_read_data1`, `rf_read_data2`, `rf_read_data3`  in  W each  signed. These are registered file outputs, valid the cycle after `rf_read_en`. They are zero in any other cycle.

## Operation
- States: IDLE, READ, CALC, WRITE, DONE.
- **IDLE:**
  - If `start` is high and any of `src_a`, `src_b`, `src_c`, `dst` is ≥ N, or `len` > N: go to DONE with `err` set. Nothing is latched.
  - Else if `start` is high and `len` = 0: go to DONE with no error.
  - Else if `start` is high: latch indices and `len` into working registers, clear `sat`, go to READ.
- **READ:** `rf_read_en`=1; `rf_read_reg1/2/3` = working a/b/c. Go to CALC.
- **CALC:**
  - Capture `rf_read_data1..3` and compute the result into a registered value.
  - Product `a*b` is 2W bits signed. The sum with sign-extended `c` is 2W+1 bits.
  - Saturate the sum to [-2^(W-1), 2^(W-1)-1], i.e. [-128, 127] for W=8. Set `sat` if clipped.
  - Go to WRITE.
- **WRITE:**
  - `rf_write_en`=1, `rf_write_reg` = working dst, `rf_write_data` = result.
  - Decrement the remaining count. Increment all four working indices, wrapping N-1 → 0.
  - If the remaining count is now 0, go to DONE; else go to READ.
- **DONE:** `done`=1 (and `err` when the command was rejected) for one cycle, then IDLE.
- `rf_read_en` and `rf_write_en` are never high in the same cycle.
- `rf_*` address and data outputs are 0 whenever the corresponding enable is low.
- Read-after-write across operations: the WRITE of op k completes before the READ of op k+1. If dst(k) equals a source of k+1, op k+1 sees the new value.
- `start` outside IDLE is ignored. There is no queueing.

## Timing
- Reset values: state IDLE. `busy`, `done`, `err`, `sat`, all `rf_*` enables, addresses and data are 0. Working registers are 0.
- Reset asserted mid-run takes effect at the next edge: FSM to IDLE, no further writes, no `done`. A write already clocked into the file is not undone.
- Start accepted at edge T. READ/CALC/WRITE of op i occupy cycles T+1+3i, T+2+3i, T+3+3i.
- `done` is high in cycle T+1+3·len. `busy` is high in cycles T+1 .. T+1+3·len inclusive.
- Rejected or len=0 command: `done` in cycle T+1. Minimum command spacing is 2 cycles.

## Structure
- Package `rf_mac_pkg`:
  - state enum;
  - default `M`/`N`/`W` constants;
  - an index-increment-with-wrap function.
- Sub-module `mac_sat`: combinational `a*b+c` with saturation, outputs result and clip flag. Parameterised by `W`.

## Test plan
- **Basic op:** regs[1]=3, regs[2]=4, regs[3]=5; start with a=1, b=2, c=3, dst=4, len=1 → regs[4]=17. `done` at T+4, `sat`=0.
- **Saturation:** a=100, b=2, c=10 → 127, `sat`=1. Then a=-100, b=2, c=-10 → -128.
- **Wrap:** len=3, src_a=13, dst=14. Ops use a indices 13, 14, 0 and dst indices 14, 0, 1. `done` at T+10.
- **Dependency:** len=2, a=0, b=1, c=2, dst=3; regs[0..4]=1,2,3,0,10. Op 0 writes regs[3]=5. Op 1 reads regs[3]=5 as its c operand and writes regs[4]=2·3+5=11.
- **Rejects:** dst=15 → `done`+`err` at T+1, no writes. len=0 → `done` only. `start` pulsed while busy → ignored, original run unchanged.
- **Reset mid-run:** reset during CALC of op 1 of a len=3 run → ops 1 and 2 are never written, outputs return to 0, no `done`.

Source files
------------

// File: rtl/rf_mac_pkg.sv
// Shared types and helpers for the register-file multiply-accumulate sequencer.
// Holds the FSM state encoding, default geometry and the index stepping rule.
package rf_mac_pkg;

    localparam int DEFAULT_M = 4;
    localparam int DEFAULT_N = 15;
    localparam int DEFAULT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } state_t;

    // Register indices step upward and wrap from the last register back to 0.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rf_mac_engine_mac_sat.sv
// Combinational signed a*b+c with saturation to the W-bit range.
// The clip flag reports when the full-precision sum did not fit.
module mac_sat #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W-1:0] result,
    output logic                clip
);

    localparam logic signed [2*W:0] MAX_V = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] MIN_V = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   sum;

    // Full-precision product and sum are wide enough that no intermediate overflows.
    always_comb begin
        prod   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        sum    = $signed({prod[2*W-1], prod}) + $signed({{(W+1){c[W-1]}}, c});
        result = sum[W-1:0];
        clip   = 1'b0;
        if (sum > MAX_V) begin
            result = MAX_V[W-1:0];
            clip   = 1'b1;
        end else if (sum < MIN_V) begin
            result = MIN_V[W-1:0];
            clip   = 1'b1;
        end
    end

endmodule

// File: rtl/rf_mac_engine.sv
// Sequencer that runs len saturating multiply-accumulates over the register file,
// stepping all four register indices after every operation.
module rf_mac_engine
    import rf_mac_pkg::*;
#(
    parameter int M = DEFAULT_M,
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [M-1:0]        len,
    input  logic [M-1:0]        src_a,
    input  logic [M-1:0]        src_b,
    input  logic [M-1:0]        src_c,
    input  logic [M-1:0]        dst,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                sat,
    output logic                rf_read_en,
    output logic [M-1:0]        rf_read_reg1,
    output logic [M-1:0]        rf_read_reg2,
    output logic [M-1:0]        rf_read_reg3,
    output logic                rf_write_en,
    output logic [M-1:0]        rf_write_reg,
    output logic signed [W-1:0] rf_write_data,
    input  logic signed [W-1:0] rf_read_data1,
    input  logic signed [W-1:0] rf_read_data2,
    input  logic signed [W-1:0] rf_read_data3
);

    localparam logic [M:0] N_VAL = (M+1)'(N);

    state_t state;

    logic [M-1:0] work_a, work_b, work_c, work_d;
    logic [M-1:0] remaining;
    logic [M-1:0] next_a, next_b, next_c, next_d;
    logic         bad_cmd;

    logic signed [W-1:0] mac_result;
    logic                mac_clip;

    mac_sat #(.W(W)) u_mac_sat (
        .a      (rf_read_data1),
        .b      (rf_read_data2),
        .c      (rf_read_data3),
        .result (mac_result),
        .clip   (mac_clip)
    );

    assign next_a = M'(next_index(32'(work_a), 32'(N)));
    assign next_b = M'(next_index(32'(work_b), 32'(N)));
    assign next_c = M'(next_index(32'(work_c), 32'(N)));
    assign next_d = M'(next_index(32'(work_d), 32'(N)));

    assign bad_cmd = ({1'b0, src_a} >= N_VAL) || ({1'b0, src_b} >= N_VAL) ||
                     ({1'b0, src_c} >= N_VAL) || ({1'b0, dst} >= N_VAL) ||
                     ({1'b0, len} > N_VAL);

    // All outputs are registered; enables, addresses and data default to zero
    // each cycle so they only carry values in the state that owns them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            sat           <= 1'b0;
            rf_read_en    <= 1'b0;
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_read_reg3  <= '0;
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            work_a        <= '0;
            work_b        <= '0;
            work_c        <= '0;
            work_d        <= '0;
            remaining     <= '0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            rf_read_en    <= 1'b0;
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_read_reg3  <= '0;
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_cmd) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            work_a       <= src_a;
                            work_b       <= src_b;
                            work_c       <= src_c;
                            work_d       <= dst;
                            remaining    <= len;
                            sat          <= 1'b0;
                            busy         <= 1'b1;
                            state        <= READ;
                            rf_read_en   <= 1'b1;
                            rf_read_reg1 <= src_a;
                            rf_read_reg2 <= src_b;
                            rf_read_reg3 <= src_c;
                        end
                    end
                end
                READ: begin
                    state <= CALC;
                end
                CALC: begin
                    state         <= WRITE;
                    rf_write_en   <= 1'b1;
                    rf_write_reg  <= work_d;
                    rf_write_data <= mac_result;
                    if (mac_clip) begin
                        sat <= 1'b1;
                    end
                end
                WRITE: begin
                    remaining <= remaining - M'(1);
                    work_a    <= next_a;
                    work_b    <= next_b;
                    work_c    <= next_c;
                    work_d    <= next_d;
                    if (remaining == M'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= READ;
                        rf_read_en   <= 1'b1;
                        rf_read_reg1 <= next_a;
                        rf_read_reg2 <= next_b;
                        rf_read_reg3 <= next_c;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
